dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller: turns memory-stage load/store requests into aligned bus transactions.
// Latency: a valid access stalls for 1 IDLE cycle plus N REQ cycles; data appears in the DONE cycle.
// Backpressure: mdelay holds the memory stage while waiting for bus_ack; TIMEOUT REQ cycles abort with err.
module dmem_ctrl #(
    parameter int width   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] addr,
    input  logic [width-1:0] wdata,
    input  logic             w,
    input  logic             r,
    input  logic [1:0]       sel,
    output logic [width-1:0] rdata,
    output logic             mdelay,
    output logic             misalign,
    output logic             err,
    output logic             bus_req,
    output logic             bus_we,
    output logic [width-1:0] bus_addr,
    output logic [3:0]       bus_be,
    output logic [width-1:0] bus_wdata,
    input  logic             bus_ack,
    input  logic [width-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   baddr_q, baddr_d;
    logic [3:0]         be_q, be_d;
    logic               we_q, we_d;
    logic [width-1:0]   wdat_q, wdat_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [width-1:0]   rdat_q, rdat_d;
    logic               err_q, err_d;

    logic               aligned, acc_ok, acc_bad;
    logic [3:0]         be_new;
    logic [width-1:0]   wdat_new, shifted, rd_cap;

    // Decode the incoming request: alignment, byte enables and lane-replicated store data.
    always_comb begin
        aligned  = (sel == 2'b00) ||
                   (sel == 2'b01 && !addr[0]) ||
                   (sel == 2'b10 && addr[1:0] == 2'b00);
        acc_ok   = (r || w) && (sel != 2'b11) && aligned;
        acc_bad  = (r || w) && (sel != 2'b11) && !aligned;
        be_new   = 4'b1111;
        wdat_new = wdata;
        case (sel)
            2'b00: begin
                be_new   = 4'b0001 << addr[1:0];
                wdat_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new   = 4'b0011 << addr[1:0];
                wdat_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new   = 4'b1111;
                wdat_new = wdata;
            end
        endcase
    end

    // Align the returned bus word to the requested lane and zero-extend to the access size.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_cap = {{(width-8){1'b0}}, shifted[7:0]};
            2'b01:   rd_cap = {{(width-16){1'b0}}, shifted[15:0]};
            default: rd_cap = shifted;
        endcase
        if (we_q) begin
            rd_cap = '0;
        end
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, present result in DONE.
    always_comb begin
        state_d = state_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        off_d   = off_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (acc_ok) begin
                    baddr_d = {addr[width-1:2], 2'b00};
                    be_d    = be_new;
                    we_d    = w;
                    wdat_d  = wdat_new;
                    off_d   = addr[1:0];
                    size_d  = sel;
                    cnt_d   = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    rdat_d  = rd_cap;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baddr_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            off_q   <= off_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet whenever reset is asserted, even before the next clock edge.
    always_comb begin
        mdelay    = rst_n && ((state_q == IDLE && acc_ok) || state_q == REQ);
        misalign  = rst_n && (state_q == IDLE) && acc_bad;
        bus_req   = rst_n && (state_q == REQ);
        bus_we    = rst_n && we_q;
        bus_addr  = rst_n ? baddr_q : '0;
        bus_be    = rst_n ? be_q    : '0;
        bus_wdata = rst_n ? wdat_q  : '0;
        rdata     = (rst_n && state_q == DONE) ? rdat_q : '0;
        err       = rst_n && (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected bus and response records, a monitor checks them.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
// The bus side is driven by the stimulus task with a per-access ack delay (0 means never ack).
module tb_dmem_ctrl;

    logic        clk, rst_n;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        w, r, mdelay, misalign, err, bus_req, bus_we, bus_ack;
    logic [1:0]  sel;
    logic [3:0]  bus_be;

    dmem_ctrl #(.width(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .w(w), .r(r), .sel(sel),
        .rdata(rdata), .mdelay(mdelay), .misalign(misalign), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } bexp_t;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          md;
    } rexp_t;

    bexp_t bq[$];
    rexp_t rq[$];
    int    mq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT starts a bus request, flags misalign, or finishes.
    bexp_t cur;
    logic  prev_md = 1'b0, prev_breq = 1'b0;
    int    run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_md = 1'b0; prev_breq = 1'b0; run = 0;
        end else begin
            if (bus_req && !prev_breq) begin
                if (bq.size() == 0) chk("unexpected_bus_req", 32'd1, 32'd0);
                else cur = bq.pop_front();
            end
            if (bus_req) begin
                chk("bus_addr", bus_addr, cur.a);
                chk("bus_be", {28'd0, bus_be}, {28'd0, cur.be});
                chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
                chk("bus_wdata", bus_wdata, cur.wd);
            end
            if (misalign) begin
                if (mq.size() == 0) chk("unexpected_misalign", 32'd1, 32'd0);
                else begin
                    void'(mq.pop_front());
                    chk("misalign_mdelay", {31'd0, mdelay}, 32'd0);
                    chk("misalign_bus_req", {31'd0, bus_req}, 32'd0);
                    chk("misalign_rdata", rdata, 32'd0);
                end
            end
            if (mdelay) begin
                run++;
            end else if (prev_md) begin
                if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("done_rdata", rdata, e.rd);
                    chk("done_err", {31'd0, err}, {31'd0, e.e});
                    chk("mdelay_cycles", run, e.md);
                    chk("done_bus_req", {31'd0, bus_req}, 32'd0);
                end
                run = 0;
            end else begin
                chk("idle_rdata_err", {rdata[31:1], rdata[0] | err}, 32'd0);
            end
            prev_md   = mdelay;
            prev_breq = bus_req;
        end
    end

    // One full access: issues the request, scrambles inputs during REQ, acks at REQ cycle ack_at.
    task automatic access(input logic [31:0] a, wd, input logic ww, rr, input logic [1:0] s,
                          input int ack_at, input logic [31:0] brd,
                          input logic [31:0] ebaddr, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic eerr, input int emd);
        bit done;
        bq.push_back('{a: ebaddr, be: ebe, we: ww, wd: ewd});
        rq.push_back('{rd: erd, e: eerr, md: emd});
        addr = a; wdata = wd; w = ww; r = rr; sel = s;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            if (!mdelay) begin
                done = 1'b1;
            end else begin
                addr      = a ^ 32'hFFFF_0001;
                wdata     = ~wd;
                bus_ack   = (k == ack_at);
                bus_rdata = (k == ack_at) ? brd : 32'h5A5A_5A5A;
            end
        end
        if (!done) chk("access_timeout", 32'd1, 32'd0);
        bus_ack = 1'b0;
        addr = a; wdata = wd;
        @(posedge clk); #1;
        w = 1'b0; r = 1'b0; sel = 2'b11;
        @(posedge clk); #1;
    endtask

    task automatic mis(input logic [31:0] a, input logic ww, rr, input logic [1:0] s);
        mq.push_back(1);
        addr = a; w = ww; r = rr; sel = s;
        @(posedge clk); #1;
        w = 1'b0; r = 1'b0; sel = 2'b11;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr = 32'h100; wdata = 32'hFFFF_FFFF; w = 1'b0; r = 1'b1; sel = 2'b10;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mdelay", {31'd0, mdelay}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_misc", {28'd0, misalign, err, bus_we, 1'b0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        r = 1'b0; sel = 2'b11; wdata = 32'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LW, ack in 3rd REQ cycle
        access(32'h100, 32'h0, 1'b0, 1'b1, 2'b10, 3, 32'hDEAD_BEEF,
               32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
        // SB to lane 3, immediate ack
        access(32'h203, 32'h0000_00A5, 1'b1, 1'b0, 2'b00, 1, 32'h1111_1111,
               32'h200, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
        // LH upper half, zero-extended
        access(32'h302, 32'h0, 1'b0, 1'b1, 2'b01, 1, 32'h8001_FFFF,
               32'h300, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 2);
        // LB lane 1
        access(32'h101, 32'h0, 1'b0, 1'b1, 2'b00, 2, 32'h1122_3344,
               32'h100, 4'b0010, 32'h0, 32'h0000_0033, 1'b0, 3);
        // LB lane 3
        access(32'h003, 32'h0, 1'b0, 1'b1, 2'b00, 1, 32'hAABB_CCDD,
               32'h000, 4'b1000, 32'h0, 32'h0000_00AA, 1'b0, 2);
        // SH upper half
        access(32'h202, 32'hABCD_1234, 1'b1, 1'b0, 2'b01, 1, 32'h0,
               32'h200, 4'b1100, 32'h1234_1234, 32'h0, 1'b0, 2);
        // r and w together is a write; read data stays 0
        access(32'h400, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b10, 2, 32'hFFFF_FFFF,
               32'h400, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
        // no ack: 16 REQ cycles, then error
        access(32'h104, 32'h0, 1'b0, 1'b1, 2'b10, 0, 32'h0,
               32'h104, 4'b1111, 32'h0, 32'h0, 1'b1, 17);

        // misaligned accesses
        mis(32'h101, 1'b0, 1'b1, 2'b10);
        mis(32'h103, 1'b1, 1'b0, 2'b01);

        // no-op requests
        addr = 32'h100; r = 1'b1; sel = 2'b11; #1;
        chk("noop_sel11", {30'd0, mdelay, misalign}, 32'd0);
        r = 1'b0; w = 1'b0; sel = 2'b10; #1;
        chk("noop_rw0", {30'd0, mdelay, misalign}, 32'd0);
        @(posedge clk); #1;
        sel = 2'b11;

        // reset in 2nd REQ cycle abandons the access
        bq.push_back('{a: 32'h500, be: 4'b1111, we: 1'b0, wd: 32'h0});
        addr = 32'h500; r = 1'b1; sel = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("abort_comb_bus_req", {31'd0, bus_req}, 32'd0);
        chk("abort_comb_mdelay", {31'd0, mdelay}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; r = 1'b0; sel = 2'b11; #1;
        chk("abort_bus_req", {31'd0, bus_req}, 32'd0);
        chk("abort_bus_addr", bus_addr, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // request held through reset is taken as new once reset releases
        rst_n = 1'b0; addr = 32'h600; r = 1'b1; sel = 2'b10;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(32'h600, 32'h0, 1'b0, 1'b1, 2'b10, 1, 32'h0BAD_F00D,
               32'h600, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("bq_drained", bq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
